// File: rtl/core_lsu_wbuf.sv
`default_nettype none
// ============================================================================
//  Module   : core_lsu_wbuf
//  Purpose  : In-order store write buffer between the M2 store path and the
//             dram manager write port. Merges consecutive cached stores to
//             the same word, forwards buffered bytes to younger loads and
//             supports a drain barrier for fences / cacop.
//  Ports    : st_*   - store push (valid/ready) with address, data, strobes,
//                      uncached flag and way select
//             dm_*   - head entry presented to the dram manager (valid/ready)
//             fwd_*  - combinational load-forwarding probe
//             drain_i, pending_o, empty_o, count_o - barrier and status
//  Revision : 1.0 - initial release
// ============================================================================
module core_lsu_wbuf #(
  parameter int DEPTH   = 4,
  parameter int WAY_CNT = 2,
  parameter int PA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [PA_W-1:0]            st_paddr_i,
  input  logic [31:0]                st_wdata_i,
  input  logic [3:0]                 st_strobe_i,
  input  logic                       st_uncached_i,
  input  logic [WAY_CNT-1:0]         st_sel_i,
  output logic                       dm_we_valid_o,
  input  logic                       dm_we_ready_i,
  output logic [PA_W-1:0]            dm_paddr_o,
  output logic [31:0]                dm_wdata_o,
  output logic [3:0]                 dm_strobe_o,
  output logic                       dm_uncached_o,
  output logic [WAY_CNT-1:0]         dm_sel_o,
  input  logic [PA_W-1:0]            fwd_paddr_i,
  output logic [31:0]                fwd_data_o,
  output logic [3:0]                 fwd_mask_o,
  output logic                       fwd_conflict_o,
  input  logic                       drain_i,
  output logic                       pending_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  // Word-granular compare: byte offset bits are masked out.
  localparam logic [PA_W-1:0] c_word_mask = {{(PA_W-2){1'b1}}, 2'b00};

  // Entry payload (not reset)
  logic [PA_W-1:0]    paddr_q  [DEPTH];
  logic [31:0]        wdata_q  [DEPTH];
  logic [3:0]         strobe_q [DEPTH];
  logic               unc_q    [DEPTH];
  logic [WAY_CNT-1:0] sel_q    [DEPTH];

  logic [c_ptr_w-1:0] head_q, head_d;
  logic [c_ptr_w-1:0] tail_q, tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_merge;
  logic               w_alloc;
  logic [c_ptr_w-1:0] w_youngest;
  logic [c_ptr_w-1:0] w_wr_idx;
  logic [c_ptr_w-1:0] w_fidx;

  assign w_full     = (count_q == c_cnt_w'(DEPTH));
  assign w_empty    = (count_q == '0);
  assign w_youngest = tail_q - 1'b1;

  // Gated by rst_n so no push is advertised while reset is asserted.
  assign st_ready_o = rst_n && !w_full && !drain_i;
  assign w_push     = st_valid_i && st_ready_o;
  assign w_pop      = dm_we_valid_o && dm_we_ready_i;

  // The youngest entry is only the one leaving when it is also the head,
  // i.e. a pop at count==1; merging into it then would lose the store.
  assign w_merge  = w_push && !w_empty && !st_uncached_i && !unc_q[w_youngest]
                    && (((paddr_q[w_youngest] ^ st_paddr_i) & c_word_mask) == '0)
                    && !(w_pop && (count_q == c_cnt_w'(1)));
  assign w_alloc  = w_push && !w_merge;
  assign w_wr_idx = w_merge ? w_youngest : tail_q;

  // Drain side
  assign dm_we_valid_o = !w_empty;
  assign dm_paddr_o    = paddr_q[head_q];
  assign dm_wdata_o    = wdata_q[head_q];
  assign dm_strobe_o   = strobe_q[head_q];
  assign dm_uncached_o = unc_q[head_q];
  assign dm_sel_o      = sel_q[head_q];

  // Status
  assign pending_o = !w_empty;
  assign empty_o   = w_empty;
  assign count_o   = count_q;

  // Pointer / occupancy next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_alloc) tail_d = tail_q + 1'b1;
    if (w_pop)   head_d = head_q + 1'b1;
    case ({w_alloc, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload write: a merge overwrites only strobed bytes and ORs the strobes;
  // the stored address is kept since only its word part is ever compared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int b = 0; b < 4; b++) begin
        if (!w_merge || st_strobe_i[b]) begin
          wdata_q[w_wr_idx][8*b +: 8] <= st_wdata_i[8*b +: 8];
        end
      end
      strobe_q[w_wr_idx] <= w_merge ? (strobe_q[w_wr_idx] | st_strobe_i) : st_strobe_i;
      unc_q[w_wr_idx]    <= st_uncached_i;
      sel_q[w_wr_idx]    <= st_sel_i;
      if (!w_merge) begin
        paddr_q[w_wr_idx] <= st_paddr_i;
      end
    end
  end

  // Forwarding: walk oldest to youngest so later matches overwrite earlier
  // ones, leaving the youngest supplier per byte.
  always_comb begin
    fwd_data_o     = '0;
    fwd_mask_o     = '0;
    fwd_conflict_o = 1'b0;
    w_fidx         = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = head_q + c_ptr_w'(i);
      if ((c_cnt_w'(i) < count_q) &&
          (((paddr_q[w_fidx] ^ fwd_paddr_i) & c_word_mask) == '0)) begin
        if (unc_q[w_fidx]) begin
          fwd_conflict_o = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (strobe_q[w_fidx][b]) begin
              fwd_data_o[8*b +: 8] = wdata_q[w_fidx][8*b +: 8];
              fwd_mask_o[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
